// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared response codes and FSM state types for the AXI-Lite register slave
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_e;

endpackage

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - register storage with AXI/user write ports and combinational read mux
module axi_lite_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       axi_we,
    input  logic [IDX_W-1:0]           axi_idx,
    input  logic [DATA_W-1:0]          axi_wdata,
    input  logic [NUM_REGS-1:0]        hw_we,
    input  logic [NUM_REGS*DATA_W-1:0] hw_wdata,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [DATA_W-1:0]          rd_data,
    output logic [NUM_REGS*DATA_W-1:0] regs
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Storage update: an AXI write to a register shadows a same-cycle user write to it
    always_ff @(posedge ACLK) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ARESET) begin
                mem[i] <= '0;
            end else if (axi_we && (axi_idx == IDX_W'(i))) begin
                mem[i] <= axi_wdata;
            end else if (hw_we[i]) begin
                mem[i] <= hw_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read mux: unimplemented indices read as zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = mem[i];
            end
        end
    end

    genvar g;
    for (g = 0; g < NUM_REGS; g++) begin : g_export
        assign regs[g*DATA_W +: DATA_W] = mem[g];
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// rtl/axi_lite_slave_regs.sv - AXI4-Lite slave exposing a small control/status register file
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [ADDR_W-1:0]          AWADDR,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [DATA_W-1:0]          WDATA,
    input  logic                       WVALID,
    output logic                       WREADY,
    output logic [1:0]                 BRESP,
    output logic                       BVALID,
    input  logic                       BREADY,
    input  logic [ADDR_W-1:0]          ARADDR,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    output logic [DATA_W-1:0]          RDATA,
    output logic                       RVALID,
    input  logic                       RREADY,
    output logic [1:0]                 RRESP,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]        wr_stb_o,
    input  logic [NUM_REGS-1:0]        hw_we_i,
    input  logic [NUM_REGS*DATA_W-1:0] hw_wdata_i
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int IDX_N = 2 ** IDX_W;

    wr_state_e           wr_state, wr_next;
    rd_state_e           rd_state, rd_next;
    logic                live;
    logic                aw_held, w_held;
    logic [IDX_W-1:0]    aw_idx_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [1:0]          bresp_q, rresp_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [NUM_REGS-1:0] wr_stb_q;
    logic [IDX_N-1:0]    idx_ok;

    logic                aw_hs, w_hs, ar_hs, wr_commit, axi_we;
    logic [IDX_W-1:0]    wr_idx, rd_idx;
    logic [DATA_W-1:0]   wr_data, rf_rdata;

    // Byte-lane bits of the addresses are don't-care: accesses are whole words
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

    // Word indices at or above NUM_REGS are unimplemented and answer SLVERR
    always_comb begin
        for (int i = 0; i < IDX_N; i++) begin
            idx_ok[i] = (i < NUM_REGS);
        end
    end

    assign AWREADY  = live && (wr_state == WR_IDLE) && !aw_held;
    assign WREADY   = live && (wr_state == WR_IDLE) && !w_held;
    assign ARREADY  = live && (rd_state == RD_IDLE);
    assign BVALID   = (wr_state == WR_RESP);
    assign RVALID   = (rd_state == RD_DATA);
    assign BRESP    = bresp_q;
    assign RRESP    = rresp_q;
    assign RDATA    = rdata_q;
    assign wr_stb_o = wr_stb_q;

    assign aw_hs     = AWVALID && AWREADY;
    assign w_hs      = WVALID && WREADY;
    assign ar_hs     = ARVALID && ARREADY;
    assign wr_idx    = aw_held ? aw_idx_q : AWADDR[ADDR_W-1:2];
    assign wr_data   = w_held ? w_data_q : WDATA;
    assign wr_commit = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    assign axi_we    = wr_commit && idx_ok[wr_idx];
    assign rd_idx    = ARADDR[ADDR_W-1:2];

    // Handshake readiness comes up one edge after reset is released
    always_ff @(posedge ACLK) begin
        live <= !ARESET;
    end

    // Write channel state and latched address/data; reset abandons any partial write
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state <= WR_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            bresp_q  <= RESP_OKAY;
            wr_stb_q <= '0;
        end else begin
            wr_state <= wr_next;
            wr_stb_q <= axi_we ? (NUM_REGS'(1) << wr_idx) : '0;
            if (wr_commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= idx_ok[wr_idx] ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= AWADDR[ADDR_W-1:2];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= WDATA;
                end
            end
        end
    end

    // Write next state: respond once address and data are both in hand
    always_comb begin
        wr_next = wr_state;
        unique case (wr_state)
            WR_IDLE: if (wr_commit) wr_next = WR_RESP;
            WR_RESP: if (BREADY)    wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    // Read channel state and captured response; data is the pre-write register value
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state <= RD_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) begin
                rdata_q <= rf_rdata;
                rresp_q <= idx_ok[rd_idx] ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Read next state: hold the response until the master accepts it
    always_comb begin
        rd_next = rd_state;
        unique case (rd_state)
            RD_IDLE: if (ar_hs)  rd_next = RD_DATA;
            RD_DATA: if (RREADY) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    axi_lite_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .axi_we    (axi_we),
        .axi_idx   (wr_idx),
        .axi_wdata (wr_data),
        .hw_we     (hw_we_i),
        .hw_wdata  (hw_wdata_i),
        .rd_idx    (rd_idx),
        .rd_data   (rf_rdata),
        .regs      (regs_o)
    );

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb/tb_axi_lite_slave_regs.sv - self-checking bench for the AXI-Lite register slave
module tb_axi_lite_slave_regs;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [3:0]   AWADDR, ARADDR;
    logic         AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic [31:0]  WDATA;
    logic [3:0]   hw_we_i;
    logic [127:0] hw_wdata_i;

    logic         AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]   BRESP, RRESP;
    logic [31:0]  RDATA;
    logic [127:0] regs_o;
    logic [3:0]   wr_stb_o;

    logic         AWREADY2, WREADY2, BVALID2, ARREADY2, RVALID2;
    logic [1:0]   BRESP2, RRESP2;
    logic [31:0]  RDATA2;
    logic [63:0]  regs2_o;
    logic [1:0]   wr_stb2_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m4 [4];
    logic [31:0] m2 [2];

    always #5 ACLK = ~ACLK;

    axi_lite_slave_regs #(.ADDR_W(4), .DATA_W(32), .NUM_REGS(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP),
        .regs_o(regs_o), .wr_stb_o(wr_stb_o),
        .hw_we_i(hw_we_i), .hw_wdata_i(hw_wdata_i)
    );

    axi_lite_slave_regs #(.ADDR_W(4), .DATA_W(32), .NUM_REGS(2)) dut2 (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY2),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY2),
        .BRESP(BRESP2), .BVALID(BVALID2), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY2),
        .RDATA(RDATA2), .RVALID(RVALID2), .RREADY(RREADY), .RRESP(RRESP2),
        .regs_o(regs2_o), .wr_stb_o(wr_stb2_o),
        .hw_we_i(hw_we_i[1:0]), .hw_wdata_i(hw_wdata_i[63:0])
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [127:0] pack4();
        return {m4[3], m4[2], m4[1], m4[0]};
    endfunction

    function automatic logic [63:0] pack2();
        return {m2[1], m2[0]};
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_regs4"}, regs_o, pack4());
        chk({tag, "_regs2"}, {64'h0, regs2_o}, {64'h0, pack2()});
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) m4[i] = '0;
        for (int i = 0; i < 2; i++) m2[i] = '0;
    endtask

    // lead > 0: W issued lead cycles before AW; lead < 0: AW first
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input int lead, input int bdly, input string tag);
        int aw_t, w_t, cyc;
        bit aw_done, w_done, hs_aw, hs_w;
        int idx;
        logic [3:0] stb4;
        logic [1:0] stb2;
        logic [1:0] e2;
        idx  = int'(addr[3:2]);
        aw_t = (lead > 0) ? lead : 0;
        w_t  = (lead < 0) ? -lead : 0;
        aw_done = 0; w_done = 0; cyc = 0;
        AWADDR = addr;
        WDATA  = data;
        BREADY = 1'b0;
        while (!(aw_done && w_done) && cyc < 40) begin
            AWVALID = !aw_done && (cyc >= aw_t);
            WVALID  = !w_done && (cyc >= w_t);
            if (w_done && !aw_done) chk({tag, "_wready_low"}, WREADY, 0);
            if (aw_done && !w_done) chk({tag, "_awready_low"}, AWREADY, 0);
            hs_aw = AWVALID && AWREADY;
            hs_w  = WVALID && WREADY;
            tick();
            aw_done = aw_done || hs_aw;
            w_done  = w_done || hs_w;
            cyc++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        chk({tag, "_hs_in_budget"}, (cyc < 40), 1);
        m4[idx] = data;
        stb4 = 4'b0001 << idx;
        if (idx < 2) begin
            m2[idx] = data;
            stb2 = 2'b01 << idx;
            e2 = OKAY;
        end else begin
            stb2 = 2'b00;
            e2 = SLVERR;
        end
        check_regs(tag);
        chk({tag, "_stb4"}, wr_stb_o, stb4);
        chk({tag, "_stb2"}, wr_stb2_o, stb2);
        for (int k = 0; k <= bdly; k++) begin
            if (k > 0) begin
                chk({tag, "_stb4_off"}, wr_stb_o, 0);
                chk({tag, "_stb2_off"}, wr_stb2_o, 0);
            end
            chk({tag, "_bvalid"}, BVALID, 1);
            chk({tag, "_bresp"}, BRESP, OKAY);
            chk({tag, "_bvalid2"}, BVALID2, 1);
            chk({tag, "_bresp2"}, BRESP2, e2);
            chk({tag, "_awready_resp"}, AWREADY, 0);
            if (k < bdly) tick();
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk({tag, "_bvalid_done"}, BVALID, 0);
        chk({tag, "_stb_done"}, wr_stb_o, 0);
        chk({tag, "_awready_back"}, AWREADY, 1);
        check_regs({tag, "_after"});
    endtask

    task automatic axi_read(input logic [3:0] addr, input int rdly, input string tag);
        int idx, cyc;
        bit done, hs;
        logic [31:0] e4, e2;
        logic [1:0] r2;
        idx = int'(addr[3:2]);
        e4  = m4[idx];
        e2  = (idx < 2) ? m2[idx] : 32'h0;
        r2  = (idx < 2) ? OKAY : SLVERR;
        ARADDR  = addr;
        ARVALID = 1'b1;
        RREADY  = 1'b0;
        done = 0; cyc = 0;
        while (!done && cyc < 40) begin
            hs = ARREADY;
            tick();
            done = hs;
            cyc++;
        end
        ARVALID = 1'b0;
        chk({tag, "_ar_in_budget"}, done, 1);
        for (int k = 0; k <= rdly; k++) begin
            chk({tag, "_rvalid"}, RVALID, 1);
            chk({tag, "_rdata"}, RDATA, e4);
            chk({tag, "_rresp"}, RRESP, OKAY);
            chk({tag, "_rdata2"}, RDATA2, e2);
            chk({tag, "_rresp2"}, RRESP2, r2);
            chk({tag, "_arready_low"}, ARREADY, 0);
            if (k < rdly) tick();
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        chk({tag, "_rvalid_done"}, RVALID, 0);
        chk({tag, "_arready_back"}, ARREADY, 1);
    endtask

    initial begin
        logic [31:0] old0;
        logic [3:0]  mask;
        logic [31:0] rnd [4];

        ARESET = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        hw_we_i = '0; hw_wdata_i = '0;
        clear_model();

        // reset state
        tick();
        tick();
        check_regs("rst");
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_bresp", BRESP, OKAY);
        chk("rst_rresp", RRESP, OKAY);
        chk("rst_rdata", RDATA, 0);
        chk("rst_stb", wr_stb_o, 0);
        ARESET = 1'b0;
        tick();
        chk("rel_awready", AWREADY, 1);
        chk("rel_wready", WREADY, 1);
        chk("rel_arready", ARREADY, 1);

        // 1: AW and W together
        axi_write(4'h4, 32'hDEADBEEF, 0, 0, "t1");
        chk("t1_reg1", regs_o[63:32], 32'hDEADBEEF);

        // 2: W three cycles before AW, slow BREADY
        axi_write(4'h8, 32'h12345678, -3 * -1, 5, "t2");
        axi_write(4'h0, 32'hCAFEF00D, -2, 1, "t2b");

        // 3: read with master-style RREADY one cycle after RVALID
        axi_read(4'h8, 1, "t3");
        chk("t3_rdata_lit", RDATA, 32'h12345678);

        // 4: unimplemented index on the two-register instance
        axi_write(4'hC, 32'h0BADC0DE, 0, 0, "t4w");
        axi_read(4'hC, 2, "t4r");
        axi_read(4'hD, 0, "t4r_lsb");

        // 5: AXI write, user write and AXI read on reg0 at the same edge
        old0 = m4[0];
        AWADDR = 4'h0; WDATA = 32'h0000000A; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 4'h0; ARVALID = 1'b1;
        hw_we_i = 4'b0001; hw_wdata_i = 128'h0000000B;
        chk("t5_ready_all", {AWREADY, WREADY, ARREADY}, 3'b111);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0; hw_we_i = '0;
        m4[0] = 32'h0000000A;
        m2[0] = 32'h0000000A;
        chk("t5_rdata_old", RDATA, old0);
        chk("t5_rdata2_old", RDATA2, old0);
        chk("t5_rvalid", RVALID, 1);
        chk("t5_bvalid", BVALID, 1);
        chk("t5_reg0", regs_o[31:0], 32'h0000000A);
        check_regs("t5");
        BREADY = 1'b1; RREADY = 1'b1;
        tick();
        BREADY = 1'b0; RREADY = 1'b0;
        chk("t5_bvalid_done", BVALID, 0);
        chk("t5_rvalid_done", RVALID, 0);
        check_regs("t5_after");

        // 6: reset with AW latched and W not yet delivered
        AWADDR = 4'h4; AWVALID = 1'b1;
        chk("t6_awready_pre", AWREADY, 1);
        tick();
        AWVALID = 1'b0;
        chk("t6_aw_held", AWREADY, 0);
        chk("t6_w_open", WREADY, 1);
        WDATA = 32'h55AA55AA; WVALID = 1'b1; ARESET = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("t6_in_rst_awready", AWREADY, 0);
        chk("t6_in_rst_wready", WREADY, 0);
        chk("t6_in_rst_regs", regs_o, 0);
        tick();
        ARESET = 1'b0;
        tick();
        clear_model();
        chk("t6_awready", AWREADY, 1);
        chk("t6_wready", WREADY, 1);
        chk("t6_bvalid", BVALID, 0);
        check_regs("t6");
        tick();
        chk("t6_bvalid_later", BVALID, 0);
        chk("t6_stb_later", wr_stb_o, 0);

        // randomized mix of writes, reads and user writes against the model
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 2))
                0: axi_write(4'($urandom_range(0, 15)), $urandom,
                             int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)), "rw");
                1: axi_read(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), "rr");
                default: begin
                    mask = 4'($urandom_range(0, 15));
                    for (int i = 0; i < 4; i++) rnd[i] = $urandom;
                    hw_we_i = mask;
                    hw_wdata_i = {rnd[3], rnd[2], rnd[1], rnd[0]};
                    tick();
                    hw_we_i = '0;
                    for (int i = 0; i < 4; i++) if (mask[i]) m4[i] = rnd[i];
                    for (int i = 0; i < 2; i++) if (mask[i]) m2[i] = rnd[i];
                    check_regs("rhw");
                    chk("rhw_stb", wr_stb_o, 0);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
